// File: rtl/edge_row_cache.sv
// Multi-line adjacency-row cache answering (from,to) edge-weight queries; misses fetch a whole row
// over a single-outstanding Avalon-style read master into a round-robin victim line.
module edge_row_cache #(
    parameter int MAX_NODES   = 64,
    parameter int INDEX_WIDTH = 6,
    parameter int VALUE_WIDTH = 32,
    parameter int MADDR_WIDTH = 32,
    parameter int MDATA_WIDTH = 32,
    parameter int NUM_LINES   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [MADDR_WIDTH-1:0] base_address,
    input  logic [INDEX_WIDTH:0]   number_of_nodes,
    input  logic                   query_valid,
    output logic                   query_ready,
    input  logic [INDEX_WIDTH-1:0] from_node,
    input  logic [INDEX_WIDTH-1:0] to_node,
    output logic                   result_valid,
    output logic [VALUE_WIDTH-1:0] result_value,
    output logic                   result_error,
    output logic                   result_hit,
    output logic [MADDR_WIDTH-1:0] mem_addr,
    output logic                   mem_read,
    input  logic                   mem_waitrequest,
    input  logic [MDATA_WIDTH-1:0] mem_readdata,
    input  logic                   mem_readdatavalid
);
    localparam int BYTES = MDATA_WIDTH / 8;
    localparam int LW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [INDEX_WIDTH:0] COL_ONE = 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [MADDR_WIDTH-1:0] base_q;
    logic [INDEX_WIDTH:0]   n_q;
    logic [INDEX_WIDTH:0]   column;
    logic [INDEX_WIDTH-1:0] to_q;
    logic [NUM_LINES-1:0]   line_valid;
    logic [INDEX_WIDTH-1:0] line_tag  [NUM_LINES];
    logic [VALUE_WIDTH-1:0] line_data [NUM_LINES][MAX_NODES];
    logic [LW-1:0]          victim;

    logic                   out_of_range;
    logic                   hit;
    logic [LW-1:0]          hit_line;
    logic                   capture;
    logic                   last_word;
    logic [MADDR_WIDTH-1:0] row_offset;

    assign query_ready  = (state == IDLE);
    assign mem_read     = (state == REQ);
    assign result_valid = (state == RESP);

    assign out_of_range = ({1'b0, from_node} >= n_q) || ({1'b0, to_node} >= n_q);
    assign capture      = (state == WAIT) && mem_readdatavalid;
    assign last_word    = ((column + COL_ONE) == n_q);
    assign row_offset   = MADDR_WIDTH'(from_node) * MADDR_WIDTH'(n_q) * MADDR_WIDTH'(BYTES);

    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!hit && line_valid[i] && (line_tag[i] == from_node)) begin
                hit      = 1'b1;
                hit_line = LW'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (query_valid && !load) state_next = (out_of_range || hit) ? RESP : REQ;
            REQ:  if (!mem_waitrequest) state_next = WAIT;
            WAIT: if (mem_readdatavalid) state_next = last_word ? RESP : REQ;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_q       <= '0;
            n_q          <= '0;
            column       <= '0;
            to_q         <= '0;
            line_valid   <= '0;
            victim       <= '0;
            result_value <= '0;
            result_error <= 1'b0;
            result_hit   <= 1'b0;
            mem_addr     <= '0;
            for (int i = 0; i < NUM_LINES; i++) line_tag[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        base_q     <= base_address;
                        n_q        <= number_of_nodes;
                        line_valid <= '0;
                    end else if (query_valid) begin
                        to_q <= to_node;
                        if (out_of_range) begin
                            result_value <= '0;
                            result_error <= 1'b1;
                            result_hit   <= 1'b1;
                        end else if (hit) begin
                            result_value <= line_data[hit_line][to_node];
                            result_error <= 1'b0;
                            result_hit   <= 1'b1;
                        end else begin
                            line_valid[victim] <= 1'b0;
                            line_tag[victim]   <= from_node;
                            column             <= '0;
                            mem_addr           <= base_q + row_offset;
                        end
                    end
                end
                WAIT: begin
                    if (mem_readdatavalid) begin
                        column   <= column + COL_ONE;
                        mem_addr <= mem_addr + MADDR_WIDTH'(BYTES);
                        if (last_word) begin
                            line_valid[victim] <= 1'b1;
                            victim <= (victim == LW'(NUM_LINES - 1)) ? '0 : victim + LW'(1);
                            // The requested word may be the one arriving right now.
                            result_value <= (to_q == column[INDEX_WIDTH-1:0])
                                          ? mem_readdata[VALUE_WIDTH-1:0]
                                          : line_data[victim][to_q];
                            result_error <= 1'b0;
                            result_hit   <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (capture) line_data[victim][column[INDEX_WIDTH-1:0]] <= mem_readdata[VALUE_WIDTH-1:0];
    end
endmodule

// File: tb/tb_edge_row_cache.sv
// Directed bench for edge_row_cache: memory word at byte address a reads as {16'hBEEF, a[15:0]}.
module tb_edge_row_cache;
    logic        clock = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] base_address;
    logic [6:0]  number_of_nodes;
    logic        query_valid;
    logic        query_ready;
    logic [5:0]  from_node;
    logic [5:0]  to_node;
    logic        result_valid;
    logic [31:0] result_value;
    logic        result_error;
    logic        result_hit;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    edge_row_cache dut (
        .clock(clock), .reset(reset), .load(load), .base_address(base_address),
        .number_of_nodes(number_of_nodes), .query_valid(query_valid), .query_ready(query_ready),
        .from_node(from_node), .to_node(to_node), .result_valid(result_valid),
        .result_value(result_value), .result_error(result_error), .result_hit(result_hit),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hBEEF, a[15:0]};
    endfunction

    // Memory responder: grants at the negedge of a REQ cycle, returns data one cycle later.
    int          stall_left = 0;
    int          stall_seen = 0;
    int          stall_bad  = 0;
    logic [31:0] stall_expect = '0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        stale_inject = 1'b0;
    logic [31:0] rd_addr[$];

    always @(negedge clock) begin
        mem_readdatavalid = 1'b0;
        if (stale_inject) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = 32'hDEAD_BEEF;
        end else if (pend) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = mem_word(pend_addr);
            pend              = 1'b0;
        end
        if (mem_read) begin
            if (stall_left > 0) begin
                mem_waitrequest = 1'b1;
                stall_left--;
                stall_seen++;
                if (mem_addr !== stall_expect) stall_bad++;
            end else begin
                mem_waitrequest = 1'b0;
                pend      = 1'b1;
                pend_addr = mem_addr;
                rd_addr.push_back(mem_addr);
            end
        end else begin
            mem_waitrequest = 1'b0;
        end
    end

    task automatic do_load(input logic [31:0] b, input logic [6:0] n);
        @(negedge clock);
        load = 1'b1; base_address = b; number_of_nodes = n;
        @(posedge clock);
        #1 load = 1'b0;
    endtask

    task automatic issue(input logic [5:0] f, input logic [5:0] t);
        int n = 0;
        @(negedge clock);
        while (!query_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("ready_before_query", query_ready, 1);
        query_valid = 1'b1; from_node = f; to_node = t;
        @(posedge clock);
        #1 query_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [31:0] v, output logic e, output logic h, output int lat);
        lat = 0;
        while (lat < 300) begin
            @(negedge clock);
            lat++;
            if (result_valid) break;
        end
        if (!result_valid) check("result_timeout", result_valid, 1);
        v = result_value; e = result_error; h = result_hit;
    endtask

    task automatic do_query(input logic [5:0] f, input logic [5:0] t,
                            output logic [31:0] v, output logic e, output logic h, output int lat);
        issue(f, t);
        wait_result(v, e, h, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic        e, h;
        int          lat;
        int          n;

        reset = 1'b1; load = 1'b0; base_address = '0; number_of_nodes = '0;
        query_valid = 1'b0; from_node = '0; to_node = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0; mem_readdatavalid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        check("rst_query_ready", query_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_value", result_value, 0);
        check("rst_result_error", result_error, 0);
        check("rst_result_hit", result_hit, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_addr", mem_addr, 0);

        // Miss then hit
        do_load(32'h1000, 7'd4);
        rd_addr.delete();
        do_query(6'd2, 6'd3, v, e, h, lat);
        check("miss_reads", rd_addr.size(), 4);
        for (int i = 0; i < 4; i++) check("miss_addr", rd_addr[i], 32'h1020 + 32'(4 * i));
        check("miss_value", v, 32'hBEEF102C);
        check("miss_hit", h, 0);
        check("miss_error", e, 0);
        check("miss_latency", lat, 9);
        rd_addr.delete();
        do_query(6'd2, 6'd1, v, e, h, lat);
        check("hit_value", v, 32'hBEEF1024);
        check("hit_hit", h, 1);
        check("hit_latency", lat, 1);
        check("hit_no_reads", rd_addr.size(), 0);
        @(negedge clock);
        check("hit_ready_t2", query_ready, 1);

        // Round-robin eviction
        do_load(32'h1000, 7'd4);
        do_query(6'd0, 6'd2, v, e, h, lat);
        check("rr_row0_value", v, 32'hBEEF1008);
        do_query(6'd1, 6'd0, v, e, h, lat);
        check("rr_row1_value", v, 32'hBEEF1010);
        do_query(6'd2, 6'd3, v, e, h, lat);
        check("rr_row2_value", v, 32'hBEEF102C);
        check("rr_row2_hit", h, 0);
        rd_addr.delete();
        do_query(6'd1, 6'd3, v, e, h, lat);
        check("rr_row1_hit", h, 1);
        check("rr_row1_value2", v, 32'hBEEF101C);
        check("rr_row1_reads", rd_addr.size(), 0);
        do_query(6'd0, 6'd1, v, e, h, lat);
        check("rr_row0_refetch_hit", h, 0);
        check("rr_row0_refetch_reads", rd_addr.size(), 4);
        check("rr_row0_refetch_addr", rd_addr[0], 32'h1000);
        check("rr_row0_refetch_value", v, 32'hBEEF1004);

        // Range checks
        rd_addr.delete();
        do_query(6'd4, 6'd0, v, e, h, lat);
        check("range_from_error", e, 1);
        check("range_from_value", v, 0);
        check("range_from_hit", h, 1);
        check("range_from_latency", lat, 1);
        do_query(6'd0, 6'd4, v, e, h, lat);
        check("range_to_error", e, 1);
        check("range_no_reads", rd_addr.size(), 0);
        do_load(32'h1000, 7'd0);
        do_query(6'd0, 6'd0, v, e, h, lat);
        check("range_n0_error", e, 1);
        check("range_n0_reads", rd_addr.size(), 0);

        // Waitrequest stall on the first read
        do_load(32'h2000, 7'd4);
        rd_addr.delete();
        stall_seen = 0; stall_bad = 0; stall_expect = 32'h2010; stall_left = 5;
        do_query(6'd1, 6'd2, v, e, h, lat);
        check("stall_cycles", stall_seen, 5);
        check("stall_addr_changes", stall_bad, 0);
        check("stall_reads", rd_addr.size(), 4);
        check("stall_first_addr", rd_addr[0], 32'h2010);
        check("stall_last_addr", rd_addr[3], 32'h201C);
        check("stall_value", v, 32'hBEEF2018);
        check("stall_latency", lat, 14);
        do_query(6'd1, 6'd0, v, e, h, lat);
        check("stall_stored_w0", v, 32'hBEEF2010);
        check("stall_stored_hit", h, 1);
        do_query(6'd1, 6'd3, v, e, h, lat);
        check("stall_stored_w3", v, 32'hBEEF201C);

        // load during a fill is ignored
        fork
            do_query(6'd3, 6'd1, v, e, h, lat);
            begin
                repeat (4) @(posedge clock);
                do_load(32'h3000, 7'd2);
            end
        join
        check("busyload_value", v, 32'hBEEF2034);
        check("busyload_hit", h, 0);
        do_query(6'd3, 6'd2, v, e, h, lat);
        check("busyload_still_cached", h, 1);
        check("busyload_n_kept", e, 0);
        check("busyload_value2", v, 32'hBEEF2038);
        do_load(32'h2000, 7'd4);
        do_query(6'd3, 6'd2, v, e, h, lat);
        check("reload_invalidates", h, 0);
        check("reload_value", v, 32'hBEEF2038);

        // Reset during the WAIT of word 1, then stale data
        rd_addr.delete();
        issue(6'd0, 6'd1);
        n = 0;
        while (rd_addr.size() < 2 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("midfill_reached_word1", rd_addr.size(), 2);
        reset = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        stale_inject = 1'b1;
        @(posedge clock);
        #1 stale_inject = 1'b0;
        @(negedge clock);
        check("midrst_query_ready", query_ready, 1);
        check("midrst_mem_read", mem_read, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_result_value", result_value, 0);
        check("midrst_result_valid", result_valid, 0);
        check("midrst_no_more_reads", rd_addr.size(), 2);
        do_load(32'h1000, 7'd4);
        rd_addr.delete();
        do_query(6'd0, 6'd1, v, e, h, lat);
        check("midrst_refetch_hit", h, 0);
        check("midrst_refetch_reads", rd_addr.size(), 4);
        check("midrst_refetch_value", v, 32'hBEEF1004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
